// File: rtl/x_common_pkg.sv
// x_common_pkg: shared helpers for the x_* buffer blocks
package x_common_pkg;
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/x_wrap_ctr.sv
// x_wrap_ctr: pointer register that wraps from MAX-1 back to 0 by explicit compare
module x_wrap_ctr #(
  parameter int MAX = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   inc,
  input  logic                   clr,
  output logic [$clog2(MAX)-1:0] q
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == ($clog2(MAX))'(MAX - 1)) ? '0 : q + 1'b1;
endmodule

// File: rtl/x_skid_fifo.sv
// x_skid_fifo: DEPTH-entry valid/ready elastic buffer with count, afull and flush
module x_skid_fifo import x_common_pkg::*; #(
  parameter  int D_WIDTH  = 16,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  localparam int CW       = clog2p1(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               vldi,
  output logic               rdyi,
  input  logic [D_WIDTH-1:0] datai,
  output logic               vldo,
  input  logic               rdyo,
  output logic [D_WIDTH-1:0] datao,
  output logic [CW-1:0]      count,
  output logic               afull
);
  localparam int PW = $clog2(DEPTH);
  if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("x_skid_fifo: DEPTH must be >= 2 and AF_LEVEL within 1..DEPTH");
  end
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wp, rp;
  logic               push, pop;
  assign rdyi  = count != CW'(DEPTH);
  assign vldo  = count != '0;
  assign afull = count >= CW'(AF_LEVEL);
  assign push  = vldi & rdyi;
  assign pop   = vldo & rdyo;
  assign datao = mem[rp];
  x_wrap_ctr #(.MAX(DEPTH)) u_wp (.clk(clk), .rstn(rstn), .inc(push), .clr(flush), .q(wp));
  x_wrap_ctr #(.MAX(DEPTH)) u_rp (.clk(clk), .rstn(rstn), .inc(pop), .clr(flush), .q(rp));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (flush) count <= '0;
      else if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      if (push && !flush) mem[wp] <= datai;
    end
endmodule

// File: tb/tb_x_skid_fifo.sv
// tb_x_skid_fifo: directed self-checking bench for x_skid_fifo (DEPTH 4 and DEPTH 3)
module tb_x_skid_fifo;
  logic        clk = 0, rstn = 0;
  logic        flush = 0, vldi = 0, rdyo = 0;
  logic [15:0] datai = '0;
  logic        rdyi, vldo, afull;
  logic [15:0] datao;
  logic [2:0]  count;
  logic        flush3 = 0, vldi3 = 0, rdyo3 = 0;
  logic [15:0] datai3 = '0;
  logic        rdyi3, vldo3, afull3;
  logic [15:0] datao3;
  logic [1:0]  count3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  x_skid_fifo #(.D_WIDTH(16), .DEPTH(4)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .vldi(vldi), .rdyi(rdyi), .datai(datai),
    .vldo(vldo), .rdyo(rdyo), .datao(datao), .count(count), .afull(afull));

  x_skid_fifo #(.D_WIDTH(16), .DEPTH(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .flush(flush3), .vldi(vldi3), .rdyi(rdyi3), .datai(datai3),
    .vldo(vldo3), .rdyo(rdyo3), .datao(datao3), .count(count3), .afull(afull3));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({vldo, rdyi, afull, count, datao} !== {1'b0, 1'b1, 1'b0, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL reset: vldo=%0b rdyi=%0b afull=%0b count=%0d datao=%h, need 0 1 0 0 0000", vldo, rdyi, afull, count, datao);
    end
    rstn = 1;
    step();
  endtask

  task automatic test_fill;
    rdyo = 0;
    for (int i = 0; i < 4; i++) begin
      vldi = 1;
      datai = 16'hA1 + 16'(i);
      step();
      checks++;
      if (count !== 3'(i + 1) || afull !== (i + 1 >= 3) || rdyi !== (i < 3) || vldo !== 1'b1 || datao !== 16'hA1) begin
        errors++;
        $display("FAIL fill[%0d]: count=%0d afull=%0b rdyi=%0b vldo=%0b datao=%h, need %0d %0b %0b 1 00a1",
                 i, count, afull, rdyi, vldo, datao, i + 1, i + 1 >= 3, i < 3);
      end
    end
    datai = 16'hA5;
    step();
    checks++;
    if (count !== 3'd4 || rdyi !== 1'b0 || datao !== 16'hA1) begin
      errors++;
      $display("FAIL fill_overflow: count=%0d rdyi=%0b datao=%h, need 4 0 00a1", count, rdyi, datao);
    end
  endtask

  task automatic test_full_pop;
    vldi = 1;
    datai = 16'hA6;
    rdyo = 1;
    step();
    vldi = 0;
    rdyo = 0;
    checks++;
    if (count !== 3'd3 || rdyi !== 1'b1 || datao !== 16'hA2 || afull !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: count=%0d rdyi=%0b datao=%h afull=%0b, need 3 1 00a2 1", count, rdyi, datao, afull);
    end
  endtask

  task automatic test_flush;
    flush = 1;
    vldi = 1;
    rdyo = 1;
    datai = 16'hEE;
    step();
    flush = 0;
    vldi = 0;
    rdyo = 0;
    checks++;
    if (count !== 3'd0 || vldo !== 1'b0 || rdyi !== 1'b1 || afull !== 1'b0) begin
      errors++;
      $display("FAIL flush: count=%0d vldo=%0b rdyi=%0b afull=%0b, need 0 0 1 0", count, vldo, rdyi, afull);
    end
    vldi = 1;
    datai = 16'h55;
    step();
    vldi = 0;
    checks++;
    if (count !== 3'd1 || vldo !== 1'b1 || datao !== 16'h55) begin
      errors++;
      $display("FAIL flush_push: count=%0d vldo=%0b datao=%h, need 1 1 0055", count, vldo, datao);
    end
    rdyo = 1;
    step();
    rdyo = 0;
    checks++;
    if (count !== 3'd0 || vldo !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain: count=%0d vldo=%0b, need 0 0", count, vldo);
    end
  endtask

  task automatic test_stream;
    rdyo = 1;
    vldi = 1;
    for (int k = 0; k < 8; k++) begin
      datai = 16'h100 + 16'(k);
      step();
      checks++;
      if (count !== 3'd1 || vldo !== 1'b1 || datao !== 16'h100 + 16'(k)) begin
        errors++;
        $display("FAIL stream[%0d]: count=%0d vldo=%0b datao=%h, need 1 1 %h", k, count, vldo, datao, 16'h100 + 16'(k));
      end
    end
    vldi = 0;
    step();
    rdyo = 0;
    checks++;
    if (count !== 3'd0 || vldo !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: count=%0d vldo=%0b, need 0 0", count, vldo);
    end
  endtask

  task automatic test_wrap3;
    logic [15:0] q[$];
    logic [15:0] nxt = 16'h300;
    int pops = 0, cyc = 0, mcount = 0;
    bit p, o;
    while (pops < 10 && cyc < 300) begin
      vldi3 = 1'($urandom_range(0, 1));
      rdyo3 = 1'($urandom_range(0, 1));
      datai3 = nxt;
      checks++;
      if (rdyi3 !== (mcount < 3) || vldo3 !== (mcount > 0) || 32'(count3) !== mcount) begin
        errors++;
        $display("FAIL wrap3_state: rdyi=%0b vldo=%0b count=%0d, need count %0d", rdyi3, vldo3, count3, mcount);
      end
      p = vldi3 && mcount < 3;
      o = rdyo3 && mcount > 0;
      if (o) begin
        checks++;
        if (datao3 !== q[0]) begin
          errors++;
          $display("FAIL wrap3_data[%0d]: datao=%h, need %h", pops, datao3, q[0]);
        end
        void'(q.pop_front());
        pops++;
      end
      if (p) begin
        q.push_back(nxt);
        nxt++;
      end
      mcount += int'(p) - int'(o);
      step();
      cyc++;
    end
    vldi3 = 0;
    rdyo3 = 0;
    checks++;
    if (pops < 10) begin
      errors++;
      $display("FAIL wrap3_timeout: pops=%0d, need 10", pops);
    end
  endtask

  task automatic test_async_reset;
    vldi = 1;
    rdyo = 0;
    datai = 16'h77;
    step();
    step();
    vldi = 0;
    #3 rstn = 0;
    #1;
    checks++;
    if ({vldo, rdyi, count, datao} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL async_reset: vldo=%0b rdyi=%0b count=%0d datao=%h, need 0 1 0 0000", vldo, rdyi, count, datao);
    end
    vldi = 1;
    step();
    checks++;
    if ({vldo, rdyi, count, datao} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL async_reset_hold: vldo=%0b rdyi=%0b count=%0d datao=%h, need 0 1 0 0000", vldo, rdyi, count, datao);
    end
    vldi = 0;
    #3 rstn = 1;
    step();
    checks++;
    if (count !== 3'd0 || vldo !== 1'b0 || rdyi !== 1'b1) begin
      errors++;
      $display("FAIL async_release: count=%0d vldo=%0b rdyi=%0b, need 0 0 1", count, vldo, rdyi);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_flush();
    test_stream();
    test_wrap3();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/x_skid_fifo.md
# x_skid_fifo

Parametrised valid/ready buffer: a DEPTH-entry elastic stage between a producer and a consumer. It generalises the team's single-entry handshake slice to configurable depth, with an occupancy count, an almost-full flag and a synchronous flush. It has no combinational path from rdyo to rdyi or from datai to datao, so it is used to break timing and absorb backpressure bursts on switch ports.

## Interface
- D_WIDTH, 16, payload width in bits (≥1)
- DEPTH, 4, number of storage entries (≥2; need not be a power of two)
- AF_LEVEL, DEPTH-1, afull asserts when count ≥ AF_LEVEL (1..DEPTH)
- CW, $clog2(DEPTH+1), count width (derived localparam, not overridable)

- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of all entries
- vldi  in  1  producer valid
- rdyi  out  1  buffer can accept (count < DEPTH)
- datai  in  D_WIDTH  producer payload
- vldo  out  1  head entry valid (count ≠ 0)
- rdyo  in  1  consumer ready
- datao  out  D_WIDTH  head entry payload
- count  out  CW  current occupancy, 0..DEPTH
- afull  out  1  count ≥ AF_LEVEL

## Operation
- push = vldi & rdyi; pop = vldo & rdyo.
- Storage: circular array mem[0..DEPTH-1], write pointer wp, read pointer rp, both 0..DEPTH-1.
- Pointer increment: on reaching DEPTH-1 the pointer wraps to 0. This is an explicit compare, not power-of-two truncation.
- push: mem[wp] <= datai; wp advances.
- pop: rp advances.
- count update: push only gives +1; pop only gives −1; both or neither leaves it unchanged.
- rdyi, vldo and afull are decoded from the registered count only. datao = mem[rp].
- Full (count = DEPTH): rdyi = 0, so a push is impossible even if a pop happens in the same cycle.
- Empty (count = 0): vldo = 0. Data is never bypassed from datai to datao in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count holds.
- Output stability: while vldo = 1 and rdyo = 0, vldo and datao hold their values.
- flush = 1 at a clock edge: wp, rp and count go to 0. Any push or pop in that cycle is discarded. mem contents are not cleared.
- Reset: wp = rp = count = 0 and every mem entry = 0. Resulting outputs are vldo = 0, rdyi = 1, datao = 0, count = 0, afull = (AF_LEVEL = 0 ? 1 : 0), which is 0 for legal AF_LEVEL.
- Reset mid-operation: all contents are lost and the block behaves as after power-up from the next edge with rstn = 1.
- Illegal parameters (DEPTH < 2, AF_LEVEL outside 1..DEPTH): elaboration-time $error.

## Timing
- Latency: a push at edge t gives vldo = 1 with that datao after edge t (visible in cycle t+1).
- Throughput: one transfer per cycle in steady state when 0 < count < DEPTH.
- rdyi deasserts the cycle after the push that fills the last entry. It reasserts the cycle after the first pop from full.
- afull and count update on the same edge as the push or pop that changes occupancy.
- After flush, vldo = 0 and rdyi = 1 from the following cycle.

## Structure
- Shared package x_common_pkg:
  - function clog2p1(n) for count widths.
  - typedef-free; payload stays a parameter vector.
- Sub-module x_wrap_ctr #(MAX): pointer register with inc, clr and wrap-at-MAX-1 logic, async active-low reset to 0. It is instantiated twice (wp, rp).
- Count register, flag decode and memory array live in x_skid_fifo.

## Test plan
- Fill from reset: DEPTH = 4, rdyo = 0, push 0xA1..0xA4. Expected: count 1,2,3,4; afull at count = 3; rdyi = 0 after the 4th push; a 5th vldi with 0xA5 is not accepted; datao = 0xA1 throughout.
- Stream: rdyo = 1, vldi = 1 continuously with an incrementing payload. Expected: after 1 cycle of latency, datao increments every cycle, count stays 1, and there is no bubble.
- Non-power-of-two wrap: DEPTH = 3, 10 push/pop pairs with random stalls on both sides. Expected: output order equals input order and pointers wrap 2→0 with no loss.
- Full with pop: DEPTH = 4 full, vldi = 1 and rdyo = 1 in one cycle. Expected: only the pop happens, count = 3, and rdyi = 1 the next cycle.
- Flush: count = 3, assert flush with vldi = 1 and rdyo = 1. Expected: next cycle count = 0, vldo = 0, rdyi = 1, afull = 0; a later push of 0x55 appears as datao = 0x55.
- Async reset: drop rstn mid-stream between edges. Expected: immediately vldo = 0, datao = 0, count = 0, rdyi = 1, holding until rstn rises.
